// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core constants for register indices, widths and write-register select encodings
package cpu_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA = 5'd31;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam logic [1:0] RW_SEL_RA = 2'b00;
  localparam logic [1:0] RW_SEL_RT = 2'b01;
  localparam logic [1:0] RW_SEL_RD = 2'b10;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: combinational read port with reg-0 guard, reset blanking and optional write-through bypass
module regfile_rd_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clr,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] rd,
  input  logic              byp,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  always_comb q = (clr || idx == '0) ? '0 : (BYPASS != 0 && byp && rw == idx) ? din : rd;
endmodule

// File: rtl/mips_regfile.sv
// mips_regfile: integer register file, two bypassed read ports, committed-write counter.
// Define REGFILE_DEBUG_EN to add the dbg_addr/dbg_data display read port.
module mips_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_id,
  input  logic [ADDR_W-1:0] rb_id,
  input  logic [ADDR_W-1:0] rw,
  input  logic              we,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [31:0]       wcount
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`endif
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic byp;
  assign byp = we && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wcount <= '0;
    end else if (we && rw != '0) begin
      mem[rw] <= din;
      wcount <= wcount + 32'd1;
    end
  end
  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_a (
    .clr(rst), .idx(ra_id), .rd(mem[ra_id]), .byp(byp), .rw(rw), .din(din), .q(qa)
  );
  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_b (
    .clr(rst), .idx(rb_id), .rd(mem[rb_id]), .byp(byp), .rw(rw), .din(din), .q(qb)
  );
`ifdef REGFILE_DEBUG_EN
  regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0)) u_port_dbg (
    .clr(rst), .idx(dbg_addr), .rd(mem[dbg_addr]), .byp(1'b0), .rw(rw), .din(din), .q(dbg_data)
  );
`endif
endmodule

// File: tb/tb_mips_regfile.sv
// tb_mips_regfile: directed vectors with hand-computed expectations for mips_regfile
module tb_mips_regfile;
  logic clk = 0;
  logic rst, we;
  logic [4:0] ra_id, rb_id, rw;
  logic [31:0] din, qa, qb, wcount;
  int errors = 0;
  int checks = 0;
`ifdef REGFILE_DEBUG_EN
  logic [4:0] dbg_addr = 0;
  logic [31:0] dbg_data;
`endif
  mips_regfile dut (
    .clk(clk), .rst(rst), .ra_id(ra_id), .rb_id(rb_id), .rw(rw), .we(we),
    .din(din), .qa(qa), .qb(qb), .wcount(wcount)
`ifdef REGFILE_DEBUG_EN
    , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; we = 0; rw = 0; din = 0; ra_id = 0; rb_id = 0;
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      ra_id = 5'(i);
      rb_id = 5'(31 - i);
      #1;
      chk("reset_qa", qa, 32'h0);
      chk("reset_qb", qb, 32'h0);
    end
    chk("reset_wcount", wcount, 32'd0);
    we = 1; rw = 8; din = 32'hDEADBEEF;
    tick();
    we = 0; ra_id = 8;
    #1;
    chk("wr_rd_qa", qa, 32'hDEADBEEF);
    chk("wr_rd_wcount", wcount, 32'd1);
`ifdef REGFILE_DEBUG_EN
    dbg_addr = 8;
    #1;
    chk("dbg_reg8", dbg_data, 32'hDEADBEEF);
    dbg_addr = 0;
    #1;
    chk("dbg_reg0", dbg_data, 32'h0);
`endif
    we = 1; rw = 0; din = 32'h12345678; ra_id = 0;
    #1;
    chk("zero_bypass_qa", qa, 32'h0);
    tick();
    chk("zero_after_qa", qa, 32'h0);
    chk("zero_wcount", wcount, 32'd1);
    rw = 5; din = 32'h11;
    tick();
    rw = 5; din = 32'h22; ra_id = 5; rb_id = 5;
    #1;
    chk("bypass_qa", qa, 32'h22);
    chk("bypass_qb", qb, 32'h22);
    tick();
    we = 0;
    #1;
    chk("bypass_commit_qa", qa, 32'h22);
    chk("bypass_wcount", wcount, 32'd3);
    we = 1; rw = 9; din = 32'h33; ra_id = 5; rb_id = 9;
    #1;
    chk("bypass_only_b_qa", qa, 32'h22);
    chk("bypass_only_b_qb", qb, 32'h33);
    we = 0;
    #1;
    chk("no_we_no_bypass_qb", qb, 32'h0);
    we = 1;
    tick();
    we = 1; rw = 31; din = 32'h00400008;
    tick();
    we = 0; ra_id = 31; rb_id = 9;
    #1;
    chk("jal_qa", qa, 32'h00400008);
    chk("reg9_qb", qb, 32'h33);
    chk("jal_wcount", wcount, 32'd5);
    rst = 1; we = 1; rw = 3; din = 32'hFF; ra_id = 31; rb_id = 3;
    #1;
    chk("rst_blank_qa", qa, 32'h0);
    chk("rst_no_bypass_qb", qb, 32'h0);
    tick();
    rst = 0; we = 0; ra_id = 3; rb_id = 8;
    #1;
    chk("rst_prio_reg3", qa, 32'h0);
    chk("rst_clear_reg8", qb, 32'h0);
    chk("rst_prio_wcount", wcount, 32'd0);
    we = 1; rw = 3; din = 32'hA5A5A5A5;
    tick();
    we = 0;
    #1;
    chk("post_rst_reg3", qa, 32'hA5A5A5A5);
    chk("post_rst_wcount", wcount, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
